// File: rtl/conv_ctrl_fsm_v2.sv
// Convolution loop controller: runtime geometry/stride/padding, operand handshakes, output backpressure.
// Optional performance counters are built when CONV_CTRL_PERF_CNT_EN is defined.
module conv_ctrl_fsm_v2 #(
   parameter int unsigned CNT_W           = 16,
   parameter int unsigned MAX_K           = 7,
   parameter int unsigned LOG2_PSUM_DEPTH = 10
) (
   input  logic                       clk,
   input  logic                       arst_n_in,
   input  logic                       start,
   input  logic [CNT_W-1:0]           cfg_out_w,
   input  logic [CNT_W-1:0]           cfg_out_h,
   input  logic [CNT_W-1:0]           cfg_in_ch,
   input  logic [CNT_W-1:0]           cfg_out_ch,
   input  logic [CNT_W-1:0]           cfg_k,
   input  logic [1:0]                 cfg_stride,
   input  logic [CNT_W-1:0]           cfg_pad,
   output logic                       running,
   output logic                       done,
   input  logic                       data_ready,
   input  logic                       a_valid,
   input  logic                       b_valid,
   output logic                       a_ready,
   output logic                       b_ready,
   output logic                       mac_valid,
   output logic                       mac_acc_internal,
   output logic                       mac_acc_zero,
   output logic                       pad_zero,
   output logic signed [CNT_W:0]      in_x,
   output logic signed [CNT_W:0]      in_y,
   output logic [CNT_W-1:0]           kx,
   output logic [CNT_W-1:0]           ky,
   output logic [CNT_W-1:0]           ich,
   output logic [CNT_W-1:0]           och,
   output logic                       psum_we,
   output logic                       psum_re,
   output logic [LOG2_PSUM_DEPTH-1:0] psum_waddr,
   output logic [LOG2_PSUM_DEPTH-1:0] psum_raddr,
   output logic                       output_valid,
   input  logic                       output_ready,
   output logic [CNT_W-1:0]           output_x,
   output logic [CNT_W-1:0]           output_y,
   output logic [CNT_W-1:0]           output_ch
`ifdef CONV_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]                stall_cycles,
   output logic [31:0]                mac_cycles
`endif
);

   localparam int unsigned EW = CNT_W + 4;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN} state_t;
   state_t r_state, w_next;

   logic [CNT_W-1:0] r_out_w, r_out_h, r_in_ch, r_out_ch, r_k, r_pad;
   logic [1:0]       r_stride;
   logic [CNT_W-1:0] r_kx, r_ky, r_och, r_ich, r_oy, r_ox;
   logic             r_ovalid;
   logic [CNT_W-1:0] r_ox_o, r_oy_o, r_och_o;
   logic             r_done, r_psum_we;
   logic [LOG2_PSUM_DEPTH-1:0] r_psum_waddr;

   logic             w_start_ok, w_zero_cfg, w_done_set, w_in_mac, w_mac;
   logic             w_last_kx, w_last_ky, w_last_och, w_last_ich, w_last_oy, w_last_ox;
   logic             w_last_win, w_produce, w_out_stall, w_last_mac, w_tap0;
   logic [CNT_W-1:0] w_k_cl;
   logic [2:0]       w_stride;
   logic signed [EW-1:0] w_ix, w_iy, w_win, w_hin;

   assign w_start_ok = (r_state == S_IDLE) & start;
   assign w_zero_cfg = (cfg_out_w == '0) | (cfg_out_h == '0) | (cfg_in_ch == '0) |
                       (cfg_out_ch == '0) | (cfg_k == '0);
   assign w_k_cl     = (cfg_k > CNT_W'(MAX_K)) ? CNT_W'(MAX_K) : cfg_k;
   assign w_stride   = {1'b0, r_stride} + 3'd1;

   assign w_last_kx  = (r_kx  == r_k      - CNT_W'(1));
   assign w_last_ky  = (r_ky  == r_k      - CNT_W'(1));
   assign w_last_och = (r_och == r_out_ch - CNT_W'(1));
   assign w_last_ich = (r_ich == r_in_ch  - CNT_W'(1));
   assign w_last_oy  = (r_oy  == r_out_h  - CNT_W'(1));
   assign w_last_ox  = (r_ox  == r_out_w  - CNT_W'(1));
   assign w_last_win = w_last_kx & w_last_ky;
   assign w_produce  = w_last_ich & w_last_win;
   assign w_tap0     = (r_kx == '0) & (r_ky == '0);

   // Only the MAC that would overwrite an unaccepted result is held back.
   assign w_out_stall = r_ovalid & ~output_ready & w_produce;
   assign w_in_mac    = (r_state == S_MAC);
   assign w_mac       = w_in_mac & a_valid & b_valid & ~w_out_stall;
   assign w_last_mac  = w_mac & w_produce & w_last_och & w_last_oy & w_last_ox;

   // Coordinates are evaluated wide so padding and stride never wrap before the range test.
   assign w_ix  = EW'(r_ox) * EW'(w_stride) + EW'(r_kx) - EW'(r_pad);
   assign w_iy  = EW'(r_oy) * EW'(w_stride) + EW'(r_ky) - EW'(r_pad);
   assign w_win = (EW'(r_out_w) - EW'(1)) * EW'(w_stride) + EW'(r_k) - (EW'(r_pad) << 1);
   assign w_hin = (EW'(r_out_h) - EW'(1)) * EW'(w_stride) + EW'(r_k) - (EW'(r_pad) << 1);

   always_comb begin
      w_next     = r_state;
      w_done_set = 1'b0;
      case (r_state)
         S_IDLE:  if (start) begin
                     if (w_zero_cfg) w_done_set = 1'b1;
                     else            w_next     = S_LOAD;
                  end
         S_LOAD:  if (data_ready) w_next = S_MAC;
         S_MAC:   if (w_last_mac) w_next = S_DRAIN;
         S_DRAIN: if (!r_ovalid) begin
                     w_done_set = 1'b1;
                     w_next     = S_IDLE;
                  end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_state      <= S_IDLE;
         r_out_w      <= '0;
         r_out_h      <= '0;
         r_in_ch      <= '0;
         r_out_ch     <= '0;
         r_k          <= '0;
         r_pad        <= '0;
         r_stride     <= '0;
         r_kx         <= '0;
         r_ky         <= '0;
         r_och        <= '0;
         r_ich        <= '0;
         r_oy         <= '0;
         r_ox         <= '0;
         r_ovalid     <= 1'b0;
         r_ox_o       <= '0;
         r_oy_o       <= '0;
         r_och_o      <= '0;
         r_done       <= 1'b0;
         r_psum_we    <= 1'b0;
         r_psum_waddr <= '0;
      end else begin
         r_state   <= w_next;
         r_done    <= w_done_set;
         r_psum_we <= w_mac & w_last_win;
         if (w_mac & w_last_win) r_psum_waddr <= LOG2_PSUM_DEPTH'(r_och);
         if (w_start_ok) begin
            r_out_w  <= cfg_out_w;
            r_out_h  <= cfg_out_h;
            r_in_ch  <= cfg_in_ch;
            r_out_ch <= cfg_out_ch;
            r_k      <= w_k_cl;
            r_pad    <= cfg_pad;
            r_stride <= cfg_stride;
            r_kx     <= '0;
            r_ky     <= '0;
            r_och    <= '0;
            r_ich    <= '0;
            r_oy     <= '0;
            r_ox     <= '0;
         end else if (w_mac) begin
            r_kx <= w_last_kx ? '0 : r_kx + CNT_W'(1);
            if (w_last_kx) begin
               r_ky <= w_last_ky ? '0 : r_ky + CNT_W'(1);
               if (w_last_ky) begin
                  r_och <= w_last_och ? '0 : r_och + CNT_W'(1);
                  if (w_last_och) begin
                     r_ich <= w_last_ich ? '0 : r_ich + CNT_W'(1);
                     if (w_last_ich) begin
                        r_oy <= w_last_oy ? '0 : r_oy + CNT_W'(1);
                        if (w_last_oy) r_ox <= w_last_ox ? '0 : r_ox + CNT_W'(1);
                     end
                  end
               end
            end
         end
         if (w_mac & w_produce) begin
            r_ovalid <= 1'b1;
            r_ox_o   <= r_ox;
            r_oy_o   <= r_oy;
            r_och_o  <= r_och;
         end else if (r_ovalid & output_ready) begin
            r_ovalid <= 1'b0;
         end
      end
   end

`ifdef CONV_CTRL_PERF_CNT_EN
   logic [31:0] r_stall_cycles, r_mac_cycles;
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_stall_cycles <= '0;
         r_mac_cycles   <= '0;
      end else if (w_start_ok) begin
         r_stall_cycles <= '0;
         r_mac_cycles   <= '0;
      end else begin
         if (w_mac & (r_mac_cycles != '1)) r_mac_cycles <= r_mac_cycles + 32'd1;
         if (w_in_mac & ~w_mac & (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end
   assign stall_cycles = r_stall_cycles;
   assign mac_cycles   = r_mac_cycles;
`endif

   assign running          = (r_state != S_IDLE);
   assign done             = r_done;
   assign a_ready          = (r_state == S_LOAD) | (w_in_mac & ~w_out_stall);
   assign b_ready          = (r_state == S_LOAD) | (w_in_mac & ~w_out_stall);
   assign mac_valid        = w_mac;
   assign mac_acc_internal = w_in_mac & ~w_tap0;
   assign mac_acc_zero     = w_in_mac & w_tap0 & (r_ich == '0);
   assign pad_zero         = running & (w_ix[EW-1] | (w_ix >= w_win) | w_iy[EW-1] | (w_iy >= w_hin));
   assign in_x             = w_ix[CNT_W:0];
   assign in_y             = w_iy[CNT_W:0];
   assign kx               = r_kx;
   assign ky               = r_ky;
   assign ich              = r_ich;
   assign och              = r_och;
   assign psum_re          = w_mac & w_tap0;
   assign psum_raddr       = LOG2_PSUM_DEPTH'(r_och);
   assign psum_we          = r_psum_we;
   assign psum_waddr       = r_psum_waddr;
   assign output_valid     = r_ovalid;
   assign output_x         = r_ox_o;
   assign output_y         = r_oy_o;
   assign output_ch        = r_och_o;

endmodule

// File: tb/tb_conv_ctrl_fsm_v2.sv
// Bench for conv_ctrl_fsm_v2: loop-nest reference model checked every cycle plus literal pins.
module tb_conv_ctrl_fsm_v2;
   localparam int CNT_W = 16;
   localparam int LPD   = 10;

   logic clk = 1'b0, arst_n_in = 1'b0, start = 1'b0;
   logic [CNT_W-1:0] cfg_out_w = '0, cfg_out_h = '0, cfg_in_ch = '0, cfg_out_ch = '0, cfg_k = '0, cfg_pad = '0;
   logic [1:0] cfg_stride = '0;
   logic data_ready = 1'b1, a_valid = 1'b1, b_valid = 1'b1, output_ready = 1'b1;
   logic running, done, a_ready, b_ready, mac_valid, mac_acc_internal, mac_acc_zero, pad_zero;
   logic signed [CNT_W:0] in_x, in_y;
   logic [CNT_W-1:0] kx, ky, ich, och, output_x, output_y, output_ch;
   logic psum_we, psum_re, output_valid;
   logic [LPD-1:0] psum_waddr, psum_raddr;
`ifdef CONV_CTRL_PERF_CNT_EN
   logic [31:0] stall_cycles, mac_cycles;
`endif

   always #5 clk = ~clk;

   conv_ctrl_fsm_v2 #(.CNT_W(CNT_W), .MAX_K(7), .LOG2_PSUM_DEPTH(LPD)) dut (
      .clk(clk), .arst_n_in(arst_n_in), .start(start),
      .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
      .cfg_k(cfg_k), .cfg_stride(cfg_stride), .cfg_pad(cfg_pad),
      .running(running), .done(done), .data_ready(data_ready),
      .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
      .mac_valid(mac_valid), .mac_acc_internal(mac_acc_internal), .mac_acc_zero(mac_acc_zero),
      .pad_zero(pad_zero), .in_x(in_x), .in_y(in_y), .kx(kx), .ky(ky), .ich(ich), .och(och),
      .psum_we(psum_we), .psum_re(psum_re), .psum_waddr(psum_waddr), .psum_raddr(psum_raddr),
      .output_valid(output_valid), .output_ready(output_ready),
      .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
`ifdef CONV_CTRL_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .mac_cycles(mac_cycles)
`endif
   );

   int n_err = 0, n_chk = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: the run is a flat list of taps in loop order.
   typedef struct { int ox, oy, ich, och, ky, kx; } tap_t;
   tap_t q[$];
   tap_t h;
   int  m_phase, m_ox, m_oy, m_och, m_waddr, old_phase;
   bit  m_ov, m_done, m_we, ov0, have, prod, stall, emac, pz;
   int  c_w, c_h, c_ic, c_oc, c_k, c_s, c_p, ix, iy, win, hin;
   int  n_mac, n_pz00, n_gap, n_stall, n_done;
   int  acc_x[$], acc_y[$], acc_c[$], rec_ix[$], rec_iy[$];

   always @(negedge clk) begin
      if (!arst_n_in) begin
         q.delete();
         m_phase = 0; m_ov = 0; m_done = 0; m_we = 0;
      end else begin
         have  = (q.size() > 0);
         if (have) h = q[0];
         prod  = have && h.ich == c_ic - 1 && h.ky == c_k - 1 && h.kx == c_k - 1;
         stall = m_phase == 2 && m_ov && !output_ready && prod;
         emac  = m_phase == 2 && a_valid && b_valid && !stall;
         chk("running", running, m_phase != 0);
         chk("done", done, m_done);
         chk("mac_valid", mac_valid, emac);
         chk("a_ready", a_ready, m_phase == 1 || (m_phase == 2 && !stall));
         chk("b_ready", b_ready, m_phase == 1 || (m_phase == 2 && !stall));
         chk("output_valid", output_valid, m_ov);
         chk("psum_we", psum_we, m_we);
         if (m_ov) begin
            chk("output_x", output_x, m_ox);
            chk("output_y", output_y, m_oy);
            chk("output_ch", output_ch, m_och);
         end
         if (m_we) chk("psum_waddr", psum_waddr, m_waddr);
         if (m_phase == 2 && have) begin
            ix  = h.ox * c_s + h.kx - c_p;
            iy  = h.oy * c_s + h.ky - c_p;
            win = (c_w - 1) * c_s + c_k - 2 * c_p;
            hin = (c_h - 1) * c_s + c_k - 2 * c_p;
            pz  = ix < 0 || ix >= win || iy < 0 || iy >= hin;
            chk("kx", kx, h.kx);
            chk("ky", ky, h.ky);
            chk("ich", ich, h.ich);
            chk("och", och, h.och);
            chk("in_x", in_x, ix);
            chk("in_y", in_y, iy);
            chk("pad_zero", pad_zero, pz);
            chk("mac_acc_internal", mac_acc_internal, !(h.kx == 0 && h.ky == 0));
            chk("mac_acc_zero", mac_acc_zero, h.ich == 0 && h.kx == 0 && h.ky == 0);
            chk("psum_re", psum_re, emac && h.kx == 0 && h.ky == 0);
            if (emac && h.kx == 0 && h.ky == 0) chk("psum_raddr", psum_raddr, h.och);
         end
         if (done) n_done++;
         if (m_phase == 2 && !mac_valid) n_gap++;
         if (m_phase == 2 && a_valid && b_valid && !mac_valid) n_stall++;
         if (mac_valid) begin
            rec_ix.push_back(int'(in_x));
            rec_iy.push_back(int'(in_y));
            if (have && h.ox == 0 && h.oy == 0 && pad_zero) n_pz00++;
         end
         // advance the model across the coming clock edge
         old_phase = m_phase; ov0 = m_ov; m_done = 0; m_we = 0;
         if (old_phase == 3 && !ov0) begin m_done = 1; m_phase = 0; end
         if (m_ov && output_ready) begin
            acc_x.push_back(m_ox); acc_y.push_back(m_oy); acc_c.push_back(m_och);
            m_ov = 0;
         end
         if (emac) begin
            void'(q.pop_front());
            n_mac++;
            m_we = h.ky == c_k - 1 && h.kx == c_k - 1;
            m_waddr = h.och;
            if (prod) begin m_ov = 1; m_ox = h.ox; m_oy = h.oy; m_och = h.och; end
            if (q.size() == 0) m_phase = 3;
         end
         if (old_phase == 1 && data_ready) m_phase = 2;
         if (old_phase == 0 && start) begin
            c_w = cfg_out_w; c_h = cfg_out_h; c_ic = cfg_in_ch; c_oc = cfg_out_ch;
            c_k = (cfg_k > 7) ? 7 : int'(cfg_k); c_s = cfg_stride + 1; c_p = cfg_pad;
            if (c_w == 0 || c_h == 0 || c_ic == 0 || c_oc == 0 || c_k == 0) m_done = 1;
            else begin
               for (int a = 0; a < c_w; a++) for (int b = 0; b < c_h; b++)
                  for (int c = 0; c < c_ic; c++) for (int d = 0; d < c_oc; d++)
                     for (int e = 0; e < c_k; e++) for (int f = 0; f < c_k; f++)
                        q.push_back('{a, b, c, d, e, f});
               m_phase = 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_cfg(input int w, input int hh, input int ic, input int oc, input int k,
                          input int s, input int p);
      cfg_out_w = CNT_W'(w); cfg_out_h = CNT_W'(hh); cfg_in_ch = CNT_W'(ic); cfg_out_ch = CNT_W'(oc);
      cfg_k = CNT_W'(k); cfg_stride = 2'(s); cfg_pad = CNT_W'(p);
      n_mac = 0; n_pz00 = 0; n_gap = 0; n_stall = 0;
      acc_x.delete(); acc_y.delete(); acc_c.delete(); rec_ix.delete(); rec_iy.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done) seen = 1;
         else tick();
      end
      chk(nm, seen, 1);
      tick();
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_running"}, running, 0);  chk({nm, "_done"}, done, 0);
      chk({nm, "_mac_valid"}, mac_valid, 0); chk({nm, "_a_ready"}, a_ready, 0);
      chk({nm, "_b_ready"}, b_ready, 0);  chk({nm, "_acc_int"}, mac_acc_internal, 0);
      chk({nm, "_acc_zero"}, mac_acc_zero, 0); chk({nm, "_pad_zero"}, pad_zero, 0);
      chk({nm, "_in_x"}, in_x, 0); chk({nm, "_in_y"}, in_y, 0);
      chk({nm, "_kx"}, kx, 0); chk({nm, "_ky"}, ky, 0); chk({nm, "_ich"}, ich, 0); chk({nm, "_och"}, och, 0);
      chk({nm, "_psum_we"}, psum_we, 0); chk({nm, "_psum_re"}, psum_re, 0);
      chk({nm, "_psum_waddr"}, psum_waddr, 0); chk({nm, "_psum_raddr"}, psum_raddr, 0);
      chk({nm, "_output_valid"}, output_valid, 0); chk({nm, "_output_x"}, output_x, 0);
      chk({nm, "_output_y"}, output_y, 0); chk({nm, "_output_ch"}, output_ch, 0);
   endtask

   task automatic check_outs(input string nm, input int n, input int xs[4], input int ys[4], input int cs[4]);
      chk({nm, "_n_out"}, acc_x.size(), n);
      for (int i = 0; i < n && i < acc_x.size(); i++) begin
         chk({nm, "_out_x"}, acc_x[i], xs[i]);
         chk({nm, "_out_y"}, acc_y[i], ys[i]);
         chk({nm, "_out_ch"}, acc_c[i], cs[i]);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      arst_n_in = 1'b1;
      tick();

      // 2x2 output, k=3, pad=1, stride 1
      set_cfg(2, 2, 1, 1, 3, 0, 1);
      pulse_start();
      wait_done("t1_done", 200);
      chk("t1_macs", n_mac, 36);
      check_outs("t1", 4, '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{0, 0, 0, 0});
      chk("t2_pad_taps_00", n_pz00, 5);
`ifdef CONV_CTRL_PERF_CNT_EN
      chk("t1_mac_cycles", mac_cycles, 36);
`endif

      // stride 2, k=1
      set_cfg(2, 2, 1, 1, 1, 1, 0);
      pulse_start();
      wait_done("t3_done", 100);
      chk("t3_n_taps", rec_ix.size(), 4);
      if (rec_ix.size() == 4) begin
         chk("t3_ix1", rec_ix[1], 0); chk("t3_iy1", rec_iy[1], 2);
         chk("t3_ix2", rec_ix[2], 2); chk("t3_iy2", rec_iy[2], 0);
         chk("t3_ix3", rec_ix[3], 2); chk("t3_iy3", rec_iy[3], 2);
      end

      // two channels each way, a_valid gap of 3 cycles mid-kernel
      set_cfg(1, 1, 2, 2, 2, 0, 0);
      pulse_start();
      repeat (4) tick();
      a_valid = 1'b0;
      repeat (3) tick();
      a_valid = 1'b1;
      wait_done("t4_done", 100);
      chk("t4_macs", n_mac, 16);
      chk("t4_gap_cycles", n_gap, 3);
      check_outs("t4", 2, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 1, 0, 0});

      // backpressure while the second result is due
      set_cfg(2, 2, 1, 1, 3, 0, 1);
      pulse_start();
      repeat (9) tick();
      output_ready = 1'b0;
      repeat (19) tick();
      output_ready = 1'b1;
      wait_done("t5_done", 200);
      chk("t5_macs", n_mac, 36);
      chk("t5_stall_cycles", n_stall, 10);
      check_outs("t5", 4, '{0, 0, 1, 1}, '{0, 1, 0, 1}, '{0, 0, 0, 0});

      // kernel above the maximum is clamped to 7
      set_cfg(1, 1, 1, 1, 9, 0, 0);
      pulse_start();
      wait_done("clamp_done", 200);
      chk("clamp_macs", n_mac, 49);

      // zero output channel count
      set_cfg(2, 2, 1, 0, 3, 0, 1);
      pulse_start();
      chk("t6_zero_done", done, 1);
      chk("t6_zero_running", running, 0);
      tick();
      chk("t6_zero_done_pulse", done, 0);

      // asynchronous reset mid-run
      set_cfg(2, 2, 1, 1, 3, 0, 1);
      pulse_start();
      repeat (5) tick();
      #2 arst_n_in = 1'b0;
      #1 check_zero("midrst");
      tick();
      arst_n_in = 1'b1;
      n_done = 0;
      repeat (5) tick();
      chk("midrst_no_done", n_done, 0);
      chk("midrst_idle", running, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
